// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory data-port arbiter and its UART loader:
//   loader state encoding, length-prefix size and default memory depth.
package mem_port_arbiter_pkg;

  // Loader states; WRITE is the only state in which the loader owns the port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_WRITE   = 3'd5,
    ST_DONE    = 3'd6
  } ldr_state_e;

  localparam int LOAD_LEN_BYTES = 2;
  localparam int LEN_WIDTH      = 8 * LOAD_LEN_BYTES;
  localparam int MEM_LEN        = 1024;

  // True while a transfer is in flight (length prefix through last write).
  function automatic logic is_busy_state(input ldr_state_e s);
    logic busy;
    case (s)
      ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI, ST_WRITE: busy = 1'b1;
      default:                                                busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   CPU-side request bus and memory-side data port of the arbiter.
//   master: the CPU/memory environment (drives cpu_*, observes stall and mem_*)
//   slave : the arbiter (observes cpu_*, drives cpu_stall and mem_*)
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 16
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [WORD_WIDTH-1:0] cpu_wdata;
  logic                  cpu_stall;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  mem_we;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter_word_assembler.sv
// mem_port_arbiter_word_assembler
//   Collects little-endian byte pairs into 16-bit words.
//   Ports: cpu_clk/rst (async active-low), clr restarts at the low-byte phase,
//   byte_en accepts byte_in as the next data byte, word = {hi, lo},
//   word_valid pulses for one cycle right after the high byte is latched.
module mem_port_arbiter_word_assembler (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        word_valid
);
  logic       phase_q, phase_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic       valid_q, valid_d;

  // Next-state for byte latches and lo/hi phase.
  always_comb begin
    phase_d = phase_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    valid_d = 1'b0;
    if (clr) begin
      phase_d = 1'b0;
    end else if (byte_en) begin
      if (phase_q) begin
        hi_d    = byte_in;
        phase_d = 1'b0;
        valid_d = 1'b1;
      end else begin
        lo_d    = byte_in;
        phase_d = 1'b1;
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // Byte latch and phase registers.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
    end
  end

  assign word       = {hi_q, lo_q};
  assign word_valid = valid_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Owns the memory data port and shares it between the CPU load/store path
//   and a UART program loader (length-prefixed little-endian word stream,
//   written from address 0). The loader has fixed priority for its single
//   WRITE cycle; a CPU access in that cycle is stalled and retried.
//   Ports: cpu_clk, rst (async active-low), load_en level, rx_byte/rx_byte_valid
//   from the UART, bus (CPU request + memory port), load_busy, sticky load_done,
//   load_count (words written in current/last transfer).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 16,
  parameter int MEM_LEN    = mem_port_arbiter_pkg::MEM_LEN
) (
  input  logic                  cpu_clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_byte_valid,
  mem_port_arbiter_if.slave     bus,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH-1:0] load_count
);
  import mem_port_arbiter_pkg::*;

  ldr_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] count_inc_s;
  logic                  done_q, done_d;
  logic                  fin_s;
  logic                  asm_clr_s;
  logic                  asm_en_s;
  logic [15:0]           word_s;
  logic                  word_valid_s;
  logic                  ld_wr_s;

  mem_port_arbiter_word_assembler u_asm (
    .cpu_clk    (cpu_clk),
    .rst        (rst),
    .clr        (asm_clr_s),
    .byte_en    (asm_en_s),
    .byte_in    (rx_byte),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // Count saturates instead of wrapping; the address wraps separately.
  assign count_inc_s = (count_q == {ADDR_WIDTH{1'b1}}) ? count_q
                     : count_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign fin_s       = (32'(count_inc_s) == 32'(len_q));
  assign ld_wr_s     = (state_q == ST_WRITE) & word_valid_s;

  // Loader next-state; abort (load_en low) takes priority over any byte.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    done_d    = done_q;
    asm_clr_s = 1'b0;
    asm_en_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          state_d   = ST_LEN_LO;
          count_d   = {ADDR_WIDTH{1'b0}};
          done_d    = 1'b0;
          asm_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEN_LO: begin
        if (!load_en) begin
          state_d = ST_IDLE;
        end else if (rx_byte_valid) begin
          len_d[7:0] = rx_byte;
          state_d    = ST_LEN_HI;
        end else begin
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (!load_en) begin
          state_d = ST_IDLE;
        end else if (rx_byte_valid) begin
          len_d[15:8] = rx_byte;
          if ({rx_byte, len_q[7:0]} == 16'h0000) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DATA_LO;
          end
        end else begin
          state_d = ST_LEN_HI;
        end
      end
      ST_DATA_LO: begin
        if (!load_en) begin
          state_d = ST_IDLE;
        end else if (rx_byte_valid) begin
          asm_en_s = 1'b1;
          state_d  = ST_DATA_HI;
        end else begin
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_HI: begin
        if (!load_en) begin
          state_d = ST_IDLE;
        end else if (rx_byte_valid) begin
          asm_en_s = 1'b1;
          state_d  = ST_WRITE;
        end else begin
          state_d = ST_DATA_HI;
        end
      end
      ST_WRITE: begin
        // The word goes out this cycle regardless of load_en, so it is counted.
        count_d = count_inc_s;
        if (!load_en) begin
          state_d = ST_IDLE;
        end else if (fin_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (rx_byte_valid) begin
          // A byte arriving with the write is the next word's low byte.
          asm_en_s = 1'b1;
          state_d  = ST_DATA_HI;
        end else begin
          state_d = ST_DATA_LO;
        end
      end
      ST_DONE: begin
        if (!load_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loader state, length, count and sticky done registers.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      len_q   <= {LEN_WIDTH{1'b0}};
      count_q <= {ADDR_WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Port mux: loader wins its WRITE cycle, CPU is stalled and its store blocked.
  always_comb begin
    bus.cpu_stall = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_we    = bus.cpu_req & bus.cpu_we;
    if (ld_wr_s) begin
      bus.cpu_stall = bus.cpu_req;
      bus.mem_addr  = ADDR_WIDTH'(32'(count_q) % 32'(MEM_LEN));
      bus.mem_wdata = WORD_WIDTH'(word_s);
      bus.mem_we    = 1'b1;
    end else begin
      bus.cpu_stall = 1'b0;
    end
  end

  assign load_busy  = is_busy_state(state_q);
  assign load_done  = done_q;
  assign load_count = count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios with literal expectations followed by a random phase,
//   all checked every cycle against a byte-counting transfer model.
module tb_mem_port_arbiter;
  localparam int TB_MEM_LEN = 4;
  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_DONE = 2;

  logic        cpu_clk;
  logic        rst;
  logic        load_en;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        load_busy;
  logic        load_done;
  logic [15:0] load_count;

  int checks;
  int failures;

  // Reference model: transfer described by bytes accepted so far.
  int          m_mode;
  int          m_nb;
  int          m_len;
  int          m_cnt;
  bit          m_done;
  bit          m_pend;
  logic [7:0]  m_lo;
  logic [15:0] m_word;

  mem_port_arbiter_if #(.ADDR_WIDTH(16), .WORD_WIDTH(16)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH (16),
    .WORD_WIDTH (16),
    .MEM_LEN    (TB_MEM_LEN)
  ) dut (
    .cpu_clk       (cpu_clk),
    .rst           (rst),
    .load_en       (load_en),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .bus           (bus),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .load_count    (load_count)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_nb   = 0;
    m_len  = 0;
    m_cnt  = 0;
    m_done = 1'b0;
    m_pend = 1'b0;
    m_lo   = 8'h00;
    m_word = 16'h0000;
  endtask

  // Advance the model by one clock edge using the inputs of the current cycle.
  task automatic model_step();
    bit fin;
    fin = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (load_en) begin
          m_mode = M_ACT;
          m_nb   = 0;
          m_cnt  = 0;
          m_done = 1'b0;
          m_pend = 1'b0;
        end
      end
      M_ACT: begin
        if (m_pend) begin
          if (m_cnt < 65535) m_cnt++;
          fin    = (m_cnt == m_len);
          m_pend = 1'b0;
        end
        if (!load_en) begin
          m_mode = M_IDLE;
        end else if (fin) begin
          m_mode = M_DONE;
          m_done = 1'b1;
        end else if (rx_byte_valid) begin
          if (m_nb == 0) begin
            m_len = int'(rx_byte);
          end else if (m_nb == 1) begin
            m_len = m_len + 256 * int'(rx_byte);
            if (m_len == 0) begin
              m_mode = M_DONE;
              m_done = 1'b1;
            end
          end else if (((m_nb - 2) % 2) == 0) begin
            m_lo = rx_byte;
          end else begin
            m_word = {rx_byte, m_lo};
            m_pend = 1'b1;
          end
          m_nb++;
        end
      end
      M_DONE: begin
        if (!load_en) m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Per-cycle comparison of every output against the model, then model update.
  task automatic check_cycle();
    bit e_wr;
    if (!rst) model_reset();
    e_wr = (m_mode == M_ACT) && m_pend;
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_wr & bus.cpu_req));
    chk("mem_we", 32'(bus.mem_we), e_wr ? 32'd1 : 32'(bus.cpu_req & bus.cpu_we));
    chk("mem_addr", 32'(bus.mem_addr), e_wr ? 32'(m_cnt % TB_MEM_LEN) : 32'(bus.cpu_addr));
    chk("mem_wdata", 32'(bus.mem_wdata), e_wr ? 32'(m_word) : 32'(bus.cpu_wdata));
    chk("load_busy", 32'(load_busy), 32'(m_mode == M_ACT));
    chk("load_done", 32'(load_done), 32'(m_done));
    chk("load_count", 32'(load_count), 32'(m_cnt));
    if (rst) model_step();
  endtask

  // One clock cycle: compare mid-cycle, return just after the next rising edge.
  task automatic cyc();
    @(negedge cpu_clk);
    check_cycle();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    cyc();
    rx_byte_valid = 1'b0;
  endtask

  task automatic start_load();
    load_en = 1'b0;
    cyc();
    load_en = 1'b1;
    cyc();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    load_en       = 1'b0;
    rx_byte       = 8'h00;
    rx_byte_valid = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 16'h0000;
    model_reset();

    cyc();
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    cyc();

    // Basic load: 02 00 34 12 CD AB
    start_load();
    send(8'h02); send(8'h00); send(8'h34); send(8'h12);
    #1;
    chk("basic_w0_we", 32'(bus.mem_we), 32'd1);
    chk("basic_w0_addr", 32'(bus.mem_addr), 32'd0);
    chk("basic_w0_data", 32'(bus.mem_wdata), 32'h1234);
    cyc();
    send(8'hCD); send(8'hAB);
    #1;
    chk("basic_w1_addr", 32'(bus.mem_addr), 32'd1);
    chk("basic_w1_data", 32'(bus.mem_wdata), 32'hABCD);
    cyc();
    #1;
    chk("basic_count", 32'(load_count), 32'd2);
    chk("basic_done", 32'(load_done), 32'd1);
    chk("basic_busy", 32'(load_busy), 32'd0);

    // Zero length
    start_load();
    #1;
    chk("zero_done_clr", 32'(load_done), 32'd0);
    send(8'h00);
    send(8'h00);
    #1;
    chk("zero_done", 32'(load_done), 32'd1);
    chk("zero_we", 32'(bus.mem_we), 32'd0);
    chk("zero_count", 32'(load_count), 32'd0);

    // Conflict with a CPU store in the WRITE cycle
    start_load();
    send(8'h01); send(8'h00); send(8'h78); send(8'h56);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'd5;
    bus.cpu_wdata = 16'h5A5A;
    #1;
    chk("conf_stall", 32'(bus.cpu_stall), 32'd1);
    chk("conf_addr", 32'(bus.mem_addr), 32'd0);
    chk("conf_data", 32'(bus.mem_wdata), 32'h5678);
    cyc();
    #1;
    chk("retry_stall", 32'(bus.cpu_stall), 32'd0);
    chk("retry_addr", 32'(bus.mem_addr), 32'd5);
    chk("retry_data", 32'(bus.mem_wdata), 32'h5A5A);
    chk("retry_we", 32'(bus.mem_we), 32'd1);
    cyc();
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;

    // Back-to-back bytes, length 5 over a 4-word memory
    start_load();
    send(8'h05); send(8'h00);
    for (int i = 0; i < 10; i++) begin
      rx_byte       = (i % 2 == 0) ? 8'(8'h10 + i / 2) : 8'(8'hA0 + i / 2);
      rx_byte_valid = 1'b1;
      #1;
      if (i >= 2 && (i % 2) == 0) begin
        chk("b2b_we", 32'(bus.mem_we), 32'd1);
        chk("b2b_addr", 32'(bus.mem_addr), 32'(((i - 2) / 2) % 4));
      end
      cyc();
    end
    rx_byte = 8'hEE;
    #1;
    chk("wrap_addr", 32'(bus.mem_addr), 32'd0);
    chk("wrap_data", 32'(bus.mem_wdata), 32'hA414);
    cyc();
    rx_byte_valid = 1'b0;
    #1;
    chk("wrap_count", 32'(load_count), 32'd5);
    chk("wrap_done", 32'(load_done), 32'd1);

    // Abort after three data bytes
    start_load();
    send(8'h03); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    load_en = 1'b0;
    cyc();
    #1;
    chk("abort_busy", 32'(load_busy), 32'd0);
    chk("abort_done", 32'(load_done), 32'd0);
    chk("abort_count", 32'(load_count), 32'd1);
    load_en = 1'b1;
    cyc();
    #1;
    chk("restart_busy", 32'(load_busy), 32'd1);
    chk("restart_count", 32'(load_count), 32'd0);

    // Asynchronous reset mid-DATA_HI with a word already written
    send(8'h02); send(8'h00); send(8'h44); send(8'h55); send(8'h66);
    rst           = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'd9;
    bus.cpu_wdata = 16'h0909;
    #1;
    chk("areset_count", 32'(load_count), 32'd0);
    chk("areset_busy", 32'(load_busy), 32'd0);
    chk("areset_stall", 32'(bus.cpu_stall), 32'd0);
    chk("areset_we", 32'(bus.mem_we), 32'd1);
    chk("areset_addr", 32'(bus.mem_addr), 32'd9);
    cyc();
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    cyc();
    #1;
    chk("areset_relaunch", 32'(load_busy), 32'd1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if (!load_en) begin
        load_en = ($urandom_range(0, 3) == 0);
      end else begin
        load_en = ($urandom_range(0, 59) != 0);
      end
      rst           = ($urandom_range(0, 399) != 0);
      rx_byte_valid = 1'($urandom_range(0, 1));
      if (m_mode == M_ACT && m_nb == 0) begin
        rx_byte = 8'($urandom_range(0, 9));
      end else if (m_mode == M_ACT && m_nb == 1) begin
        rx_byte = 8'h00;
      end else begin
        rx_byte = 8'($urandom_range(0, 255));
      end
      bus.cpu_req   = 1'($urandom_range(0, 1));
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = 16'($urandom_range(0, 65535));
      bus.cpu_wdata = 16'($urandom_range(0, 65535));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
